battleship_game_sequencer: RTL and testbench

- Top-level game-flow controller for the 6x6 battleship design.
- Sequences the placement phase (Player 1, then Player 2) by driving the placement block's player-select. Gates phase advance on the placement-complete flags and grids.
- Then arbitrates alternating firing turns, resolves each shot against the opponent's ship grid, maintains shot/hit boards, and detects the winner.
- Grid cell index is always y*6+x, with x,y in 0..5.

---
 rtl/battleship_game_sequencer.sv | 173 +++++++++++++++++
 tb/tb_battleship_game_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/battleship_game_sequencer.sv
// Game-flow controller for the 6x6 battleship design: sequences placement of
// both players, then alternates firing turns, keeps shot boards and counts,
// and declares a winner once every opponent ship cell has been hit.
module battleship_game_sequencer #(
  parameter int unsigned MIN_SHIP_CELLS = 1,
  parameter int unsigned TURN_TIMEOUT   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        p1_placement_complete,
  input  logic        p2_placement_complete,
  input  logic [35:0] placed_ships_p1,
  input  logic [35:0] placed_ships_p2,
  input  logic        fire,
  input  logic [2:0]  target_x,
  input  logic [2:0]  target_y,
  output logic        is_p1,
  output logic [2:0]  phase,
  output logic [35:0] shots_on_p1,
  output logic [35:0] shots_on_p2,
  output logic [35:0] hits_on_p1,
  output logic [35:0] hits_on_p2,
  output logic        shot_valid,
  output logic        shot_hit,
  output logic        shot_reject,
  output logic [5:0]  shot_count_p1,
  output logic [5:0]  shot_count_p2,
  output logic [1:0]  winner,
  output logic        game_over
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLACE_P1  = 3'd1,
    PLACE_P2  = 3'd2,
    TURN_P1   = 3'd3,
    TURN_P2   = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] to_cnt;

  logic        p1_turn;
  state_t      next_turn;
  logic [35:0] opp_ships;
  logic [35:0] opp_shots;
  logic        in_range;
  logic [5:0]  cell_idx;
  logic [35:0] cell_mask;
  logic        fire_ok;
  logic [35:0] new_shots;
  logic        shot_is_hit;
  logic        all_sunk;
  logic        timeout_hit;
  logic        p1_ready;
  logic        p2_ready;

  function automatic int unsigned popcount36(input logic [35:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 36; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

  assign phase      = state;
  assign hits_on_p1 = shots_on_p1 & placed_ships_p1;
  assign hits_on_p2 = shots_on_p2 & placed_ships_p2;

  // Shot resolution against the opponent of whoever holds the turn.
  always_comb begin
    p1_turn     = (state == TURN_P1);
    next_turn   = p1_turn ? TURN_P2 : TURN_P1;
    opp_ships   = p1_turn ? placed_ships_p2 : placed_ships_p1;
    opp_shots   = p1_turn ? shots_on_p2 : shots_on_p1;
    in_range    = (target_x <= 3'd5) && (target_y <= 3'd5);
    cell_idx    = 6'(target_y) * 6'd6 + 6'(target_x);
    cell_mask   = in_range ? (36'd1 << cell_idx) : '0;
    fire_ok     = in_range && !(|(opp_shots & cell_mask));
    new_shots   = opp_shots | cell_mask;
    shot_is_hit = |(opp_ships & cell_mask);
    // Win is judged on the board as it will be after this shot lands.
    all_sunk    = ((opp_ships & ~new_shots) == '0);
    timeout_hit = (TURN_TIMEOUT != 0) && (to_cnt >= TURN_TIMEOUT - 32'd1);
    p1_ready    = popcount36(placed_ships_p1) >= MIN_SHIP_CELLS;
    p2_ready    = popcount36(placed_ships_p2) >= MIN_SHIP_CELLS;
  end

  // Game FSM with registered boards, counts, pulses and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      is_p1         <= 1'b1;
      to_cnt        <= '0;
      shots_on_p1   <= '0;
      shots_on_p2   <= '0;
      shot_valid    <= 1'b0;
      shot_hit      <= 1'b0;
      shot_reject   <= 1'b0;
      shot_count_p1 <= '0;
      shot_count_p2 <= '0;
      winner        <= 2'b00;
      game_over     <= 1'b0;
    end else begin
      shot_valid  <= 1'b0;
      shot_hit    <= 1'b0;
      shot_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= PLACE_P1;
            is_p1 <= 1'b1;
          end
        end
        PLACE_P1: begin
          if (p1_placement_complete && p1_ready) begin
            state <= PLACE_P2;
            is_p1 <= 1'b0;
          end
        end
        PLACE_P2: begin
          if (p2_placement_complete && p2_ready) begin
            state  <= TURN_P1;
            is_p1  <= 1'b1;
            to_cnt <= '0;
          end
        end
        TURN_P1, TURN_P2: begin
          // fire outranks the timeout; a rejected shot keeps the clock running.
          if (fire) begin
            if (fire_ok) begin
              shot_valid <= 1'b1;
              shot_hit   <= shot_is_hit;
              to_cnt     <= '0;
              if (p1_turn) begin
                shots_on_p2 <= new_shots;
                if (shot_count_p1 != 6'd63) shot_count_p1 <= shot_count_p1 + 6'd1;
              end else begin
                shots_on_p1 <= new_shots;
                if (shot_count_p2 != 6'd63) shot_count_p2 <= shot_count_p2 + 6'd1;
              end
              if (all_sunk) begin
                state     <= GAME_OVER;
                winner    <= p1_turn ? 2'b01 : 2'b10;
                game_over <= 1'b1;
              end else begin
                state <= next_turn;
              end
            end else begin
              shot_reject <= 1'b1;
              if (TURN_TIMEOUT != 0) to_cnt <= to_cnt + 32'd1;
            end
          end else if (timeout_hit) begin
            state  <= next_turn;
            to_cnt <= '0;
          end else if (TURN_TIMEOUT != 0) begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        GAME_OVER: begin
          game_over <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_battleship_game_sequencer.sv
// Directed bench: each step drives inputs, queues the outputs expected after
// the next clock edge, then pops and checks them 1 ns after that edge.
module tb_battleship_game_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, p1c, p2c, fire;
  logic [35:0] sh1, sh2;
  logic [2:0]  tx, ty;
  logic        is_p1;
  logic [2:0]  phase;
  logic [35:0] shots_on_p1, shots_on_p2, hits_on_p1, hits_on_p2;
  logic        shot_valid, shot_hit, shot_reject;
  logic [5:0]  shot_count_p1, shot_count_p2;
  logic [1:0]  winner;
  logic        game_over;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    string       tag;
    logic [2:0]  ph;
    bit          chk_isp1;
    logic        isp1;
    logic        v, h, r;
    logic [1:0]  w;
    logic        go;
    logic [5:0]  c1, c2;
    logic [35:0] s1, s2;
  } exp_t;

  exp_t q[$];

  localparam logic [35:0] B0  = 36'd1 << 0;
  localparam logic [35:0] B7  = 36'd1 << 7;
  localparam logic [35:0] B8  = 36'd1 << 8;
  localparam logic [35:0] B27 = 36'd1 << 27;
  localparam logic [35:0] B35 = 36'd1 << 35;

  battleship_game_sequencer #(.MIN_SHIP_CELLS(1), .TURN_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .p1_placement_complete(p1c), .p2_placement_complete(p2c),
    .placed_ships_p1(sh1), .placed_ships_p2(sh2),
    .fire(fire), .target_x(tx), .target_y(ty),
    .is_p1(is_p1), .phase(phase),
    .shots_on_p1(shots_on_p1), .shots_on_p2(shots_on_p2),
    .hits_on_p1(hits_on_p1), .hits_on_p2(hits_on_p2),
    .shot_valid(shot_valid), .shot_hit(shot_hit), .shot_reject(shot_reject),
    .shot_count_p1(shot_count_p1), .shot_count_p2(shot_count_p2),
    .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field,
                     input logic [35:0] obs, input logic [35:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp_v);
    end
  endtask

  task automatic want(input string tag, input logic [2:0] ph, input bit ci,
                      input logic ip, input logic v, input logic h, input logic r,
                      input logic [1:0] w, input logic go,
                      input logic [5:0] c1, input logic [5:0] c2,
                      input logic [35:0] s1, input logic [35:0] s2);
    exp_t e;
    e.tag = tag; e.ph = ph; e.chk_isp1 = ci; e.isp1 = ip;
    e.v = v; e.h = h; e.r = r; e.w = w; e.go = go;
    e.c1 = c1; e.c2 = c2; e.s1 = s1; e.s2 = s2;
    q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = q.pop_front();
    chk(e.tag, "phase",  36'(phase),         36'(e.ph));
    if (e.chk_isp1) chk(e.tag, "is_p1", 36'(is_p1), 36'(e.isp1));
    chk(e.tag, "valid",  36'(shot_valid),    36'(e.v));
    chk(e.tag, "hit",    36'(shot_hit),      36'(e.h));
    chk(e.tag, "reject", 36'(shot_reject),   36'(e.r));
    chk(e.tag, "winner", 36'(winner),        36'(e.w));
    chk(e.tag, "over",   36'(game_over),     36'(e.go));
    chk(e.tag, "cnt1",   36'(shot_count_p1), 36'(e.c1));
    chk(e.tag, "cnt2",   36'(shot_count_p2), 36'(e.c2));
    chk(e.tag, "shots1", shots_on_p1,        e.s1);
    chk(e.tag, "shots2", shots_on_p2,        e.s2);
    chk(e.tag, "hits1",  hits_on_p1,         e.s1 & sh1);
    chk(e.tag, "hits2",  hits_on_p2,         e.s2 & sh2);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; p1c = 1'b0; p2c = 1'b0; fire = 1'b0;
    sh1 = '0; sh2 = '0; tx = '0; ty = '0;
    #1;
    // Game 1: placement gating, hit/miss/reject handling, win.
    want("rst", 3'd0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    reset = 1'b0; start = 1'b1; p1c = 1'b1; fire = 1'b1;
    want("idle_go", 3'd1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    want("p1_short", 3'd1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    fire = 1'b0; sh1 = B0;
    want("p1_done", 3'd2, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    sh2 = B7 | B8; p2c = 1'b1;
    want("p2_done", 3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    fire = 1'b1; tx = 3'd1; ty = 3'd1;
    want("p1_hit", 3'd4, 0, 0, 1, 1, 0, 2'b00, 0, 1, 0, '0, B7); step();
    tx = 3'd6; ty = 3'd0;
    want("p2_oob", 3'd4, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0, '0, B7); step();
    tx = 3'd3; ty = 3'd4;
    want("p2_miss", 3'd3, 0, 0, 1, 0, 0, 2'b00, 0, 1, 1, B27, B7); step();
    tx = 3'd1; ty = 3'd1;
    want("p1_dup", 3'd3, 0, 0, 0, 0, 1, 2'b00, 0, 1, 1, B27, B7); step();
    tx = 3'd2; ty = 3'd1;
    want("p1_win", 3'd5, 0, 0, 1, 1, 0, 2'b01, 1, 2, 1, B27, B7 | B8); step();
    tx = 3'd0; ty = 3'd0;
    want("over_hold", 3'd5, 0, 0, 0, 0, 0, 2'b01, 1, 2, 1, B27, B7 | B8); step();
    fire = 1'b0;
    // Game 2: turn timeout, fire beating the timeout, reject not clearing it.
    reset = 1'b1;
    want("rst2", 3'd0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    reset = 1'b0;
    want("restart", 3'd1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    want("p1_again", 3'd2, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    want("p2_again", 3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    for (int i = 0; i < 3; i++) begin
      want("to_wait1", 3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    end
    want("to_expire1", 3'd4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    for (int i = 0; i < 3; i++) begin
      want("to_wait2", 3'd4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    end
    fire = 1'b1; tx = 3'd5; ty = 3'd5;
    want("fire_beats_to", 3'd3, 0, 0, 1, 0, 0, 2'b00, 0, 0, 1, B35, '0); step();
    fire = 1'b0;
    want("to_wait3", 3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, B35, '0); step();
    fire = 1'b1; tx = 3'd7; ty = 3'd0;
    want("rej_in_turn", 3'd3, 0, 0, 0, 0, 1, 2'b00, 0, 0, 1, B35, '0); step();
    fire = 1'b0;
    want("to_wait4", 3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, B35, '0); step();
    want("to_after_rej", 3'd4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, B35, '0); step();
    reset = 1'b1;
    want("rst_mid", 3'd0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, '0, '0); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
